// File: rtl/pipe_stall_sched_pkg.sv
// Shared definitions for the pipeline stall scheduler: state encodings,
// parameter defaults and legal parameter ranges.
package pipe_sched_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_LDSTALL = 2'b01,
      ST_MCWAIT  = 2'b10
   } sched_state_t;

   localparam int LD_LAT_DEF     = 1;
   localparam int LD_LAT_MIN     = 1;
   localparam int LD_LAT_MAX     = 15;
   localparam int MC_MAX_CYC_DEF = 32;
   localparam int MC_MAX_CYC_MIN = 2;
   localparam int MC_MAX_CYC_MAX = 255;
   localparam int CNT_W_DEF      = 16;

   // Internal counter widths are sized for the largest legal parameter value.
   localparam int LD_CNT_W = $clog2(LD_LAT_MAX + 1);
   localparam int MC_TMR_W = $clog2(MC_MAX_CYC_MAX);

endpackage

// File: rtl/pipe_stall_sched_sat_cnt.sv
// Enable-driven up-counter that sticks at all-ones instead of wrapping.
module sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/pipe_stall_sched.sv
// Hazard/stall scheduler for a 5-stage pipeline: load-use bubbles, redirect
// flushes and multicycle-op holds with a watchdog. Perf counters: PIPE_SCHED_PERF_EN.
module pipe_stall_sched
   import pipe_sched_pkg::*;
#(
   parameter int LD_LAT     = LD_LAT_DEF,
   parameter int MC_MAX_CYC = MC_MAX_CYC_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_hazard,
   input  logic             redirect,
   input  logic             mc_start,
   input  logic             mc_done,
   output logic             we_pc_ir,
   output logic             reset_ir,
   output logic             bubble_ex,
   output logic             mc_hold,
   output logic             mc_timeout,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   sched_state_t          state_q, state_d;
   logic [LD_CNT_W-1:0]   ld_cnt_q, ld_cnt_d;
   logic [MC_TMR_W-1:0]   tmr_q, tmr_d;
   logic                  timeout_q, timeout_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_RUN;
         ld_cnt_q  <= '0;
         tmr_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ld_cnt_q  <= ld_cnt_d;
         tmr_q     <= tmr_d;
         timeout_q <= timeout_d;
      end
   end

   // Only RUN looks at requests; the stall states ignore new ones until they exit.
   always_comb begin
      state_d   = state_q;
      ld_cnt_d  = ld_cnt_q;
      tmr_d     = tmr_q;
      timeout_d = timeout_q;
      we_pc_ir  = 1'b1;
      reset_ir  = 1'b0;
      bubble_ex = 1'b0;
      mc_hold   = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mc_start) begin
               we_pc_ir = 1'b0;
               tmr_d    = '0;
               state_d  = ST_MCWAIT;
            end else if (ld_hazard) begin
               we_pc_ir  = 1'b0;
               bubble_ex = 1'b1;
               if (LD_LAT > 1) begin
                  ld_cnt_d = LD_CNT_W'(LD_LAT - 1);
                  state_d  = ST_LDSTALL;
               end
            end else if (redirect) begin
               reset_ir = 1'b1;
            end
         end
         ST_LDSTALL: begin
            we_pc_ir  = 1'b0;
            bubble_ex = 1'b1;
            ld_cnt_d  = ld_cnt_q - LD_CNT_W'(1);
            if (ld_cnt_q == 1) begin
               state_d = ST_RUN;
            end
         end
         ST_MCWAIT: begin
            we_pc_ir = 1'b0;
            mc_hold  = 1'b1;
            tmr_d    = tmr_q + MC_TMR_W'(1);
            if (mc_done) begin
               state_d = ST_RUN;
            end else if (tmr_q == MC_TMR_W'(MC_MAX_CYC - 1)) begin
               timeout_d = 1'b1;
               state_d   = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
      // Reset must present a free-running pipe immediately, whatever the inputs say.
      if (rst) begin
         we_pc_ir  = 1'b1;
         reset_ir  = 1'b0;
         bubble_ex = 1'b0;
         mc_hold   = 1'b0;
      end
   end

   assign state      = state_q;
   assign mc_timeout = timeout_q;

`ifdef PIPE_SCHED_PERF_EN
   sat_cnt #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .en  (~we_pc_ir),
      .cnt (stall_cnt)
   );

   sat_cnt #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .rst (rst),
      .en  (reset_ir),
      .cnt (flush_cnt)
   );
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_sched.sv
// Self-checking bench for pipe_stall_sched: directed scenarios plus random
// traffic, all checked against a cycle-level behavioural model.
module tb_pipe_stall_sched;

   localparam int LD_LAT  = 3;
   localparam int MC_MAX  = 8;
   localparam int CW      = 4;
   localparam int CNT_MAX = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          ld_hazard, redirect, mc_start, mc_done;
   logic          we_pc_ir, reset_ir, bubble_ex, mc_hold, mc_timeout;
   logic [1:0]    state;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int vectors     = 0;
   int miscompares = 0;

   // Model: remaining load-stall cycles, multicycle-op progress, sticky flag, counts.
   int m_ld_left;
   bit m_in_mc;
   int m_mc_cycles;
   bit m_timeout;
   int m_stall;
   int m_flush;

   pipe_stall_sched #(
      .LD_LAT     (LD_LAT),
      .MC_MAX_CYC (MC_MAX),
      .CNT_W      (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ld_hazard  (ld_hazard),
      .redirect   (redirect),
      .mc_start   (mc_start),
      .mc_done    (mc_done),
      .we_pc_ir   (we_pc_ir),
      .reset_ir   (reset_ir),
      .bubble_ex  (bubble_ex),
      .mc_hold    (mc_hold),
      .mc_timeout (mc_timeout),
      .state      (state),
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] observed_ctl();
      return {state, we_pc_ir, reset_ir, bubble_ex, mc_hold, mc_timeout};
   endfunction

   function automatic logic [7:0] observed_cnt();
      return {stall_cnt, flush_cnt};
   endfunction

   task automatic model_reset();
      m_ld_left   = 0;
      m_in_mc     = 1'b0;
      m_mc_cycles = 0;
      m_timeout   = 1'b0;
      m_stall     = 0;
      m_flush     = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      ld_hazard = 1'b0;
      redirect  = 1'b0;
      mc_start  = 1'b0;
      mc_done   = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Drive one cycle of inputs, predict this cycle's outputs, then advance the model.
   task automatic cycle(input bit ld, input bit rd, input bit ms, input bit md,
                        output logic [6:0] exp_ctl, output logic [7:0] exp_cnt);
      logic       we, rir, bub, hold, to_next;
      logic [1:0] st;
      @(negedge clk);
      ld_hazard = ld;
      redirect  = rd;
      mc_start  = ms;
      mc_done   = md;
      #1;
      we = 1'b1; rir = 1'b0; bub = 1'b0; hold = 1'b0; st = 2'b00;
      to_next = m_timeout;
      if (m_in_mc) begin
         st = 2'b10; we = 1'b0; hold = 1'b1;
         m_mc_cycles++;
         if (md) begin
            m_in_mc = 1'b0;
         end else if (m_mc_cycles == MC_MAX) begin
            m_in_mc = 1'b0;
            to_next = 1'b1;
         end
      end else if (m_ld_left > 0) begin
         st = 2'b01; we = 1'b0; bub = 1'b1;
         m_ld_left--;
      end else if (ms) begin
         we = 1'b0;
         m_in_mc = 1'b1;
         m_mc_cycles = 0;
      end else if (ld) begin
         we = 1'b0; bub = 1'b1;
         m_ld_left = LD_LAT - 1;
      end else if (rd) begin
         rir = 1'b1;
      end
      exp_ctl = {st, we, rir, bub, hold, m_timeout};
`ifdef PIPE_SCHED_PERF_EN
      exp_cnt = {4'(m_stall), 4'(m_flush)};
`else
      exp_cnt = 8'h00;
`endif
      m_timeout = to_next;
      if (!we && m_stall < CNT_MAX) m_stall++;
      if (rir && m_flush < CNT_MAX) m_flush++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; ld_hazard = 1'b1; redirect = 1'b1; mc_start = 1'b1; mc_done = 1'b0;
      #2;
      vectors++;
      if (observed_ctl() !== 7'b00_1_0_0_0_0) begin
         miscompares++;
         $display("[TB] FAIL reset_ctl: got %b want %b", observed_ctl(), 7'b00_1_0_0_0_0);
      end
      vectors++;
      if (observed_cnt() !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL reset_cnt: got %h want 00", observed_cnt());
      end
      do_reset();
   endtask

   task automatic test_load_use();
      logic [6:0] ec;
      logic [7:0] en;
      int stalls = 0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cycle(i == 0, 1'b0, 1'b0, 1'b0, ec, en);
         if (!we_pc_ir && bubble_ex) stalls++;
         vectors++;
         if (observed_ctl() !== ec) begin
            miscompares++;
            $display("[TB] FAIL load_use_ctl cyc%0d: got %b want %b", i, observed_ctl(), ec);
         end
         vectors++;
         if (observed_cnt() !== en) begin
            miscompares++;
            $display("[TB] FAIL load_use_cnt cyc%0d: got %h want %h", i, observed_cnt(), en);
         end
      end
      vectors++;
      if (stalls != LD_LAT) begin
         miscompares++;
         $display("[TB] FAIL load_use_len: got %0d want %0d", stalls, LD_LAT);
      end
   endtask

   task automatic test_multicycle();
      logic [6:0] ec;
      logic [7:0] en;
      int holds = 0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 1'b0, i == 0, i == 5, ec, en);
         if (mc_hold) holds++;
         vectors++;
         if (observed_ctl() !== ec) begin
            miscompares++;
            $display("[TB] FAIL multicycle_ctl cyc%0d: got %b want %b", i, observed_ctl(), ec);
         end
         vectors++;
         if (observed_cnt() !== en) begin
            miscompares++;
            $display("[TB] FAIL multicycle_cnt cyc%0d: got %h want %h", i, observed_cnt(), en);
         end
      end
      vectors++;
      if (holds != 5) begin
         miscompares++;
         $display("[TB] FAIL multicycle_hold_len: got %0d want 5", holds);
      end
   endtask

   task automatic test_timeout();
      logic [6:0] ec;
      logic [7:0] en;
      do_reset();
      for (int i = 0; i < MC_MAX + 8; i++) begin
         cycle(1'b0, i == MC_MAX + 3, i == 0 || i == MC_MAX + 4, i == MC_MAX + 6, ec, en);
         vectors++;
         if (observed_ctl() !== ec) begin
            miscompares++;
            $display("[TB] FAIL timeout_ctl cyc%0d: got %b want %b", i, observed_ctl(), ec);
         end
      end
      vectors++;
      if (mc_timeout !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL timeout_sticky: got %b want 1", mc_timeout);
      end
      do_reset();
      #1;
      vectors++;
      if (mc_timeout !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL timeout_clear: got %b want 0", mc_timeout);
      end
   endtask

   task automatic test_priority();
      logic [6:0] ec;
      logic [7:0] en;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(i == 0, i == 0, i == 0, i == 2, ec, en);
         vectors++;
         if (observed_ctl() !== ec) begin
            miscompares++;
            $display("[TB] FAIL priority_ctl cyc%0d: got %b want %b", i, observed_ctl(), ec);
         end
         vectors++;
         if (observed_cnt() !== en) begin
            miscompares++;
            $display("[TB] FAIL priority_cnt cyc%0d: got %h want %h", i, observed_cnt(), en);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [6:0] ec;
      logic [7:0] en;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, i == 0, 1'b0, ec, en);
         vectors++;
         if (observed_ctl() !== ec) begin
            miscompares++;
            $display("[TB] FAIL async_pre_ctl cyc%0d: got %b want %b", i, observed_ctl(), ec);
         end
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({state, mc_hold, we_pc_ir} !== 4'b00_0_1) begin
         miscompares++;
         $display("[TB] FAIL async_reset: got %b want 0001", {state, mc_hold, we_pc_ir});
      end
      vectors++;
      if (observed_cnt() !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL async_reset_cnt: got %h want 00", observed_cnt());
      end
      do_reset();
   endtask

   task automatic test_saturation();
      logic [6:0] ec;
      logic [7:0] en;
      logic [CW-1:0] want;
      do_reset();
      for (int i = 0; i < 21; i++) begin
         cycle(1'b0, i < 20, 1'b0, 1'b0, ec, en);
         vectors++;
         if (observed_cnt() !== en) begin
            miscompares++;
            $display("[TB] FAIL saturation_cnt cyc%0d: got %h want %h", i, observed_cnt(), en);
         end
      end
`ifdef PIPE_SCHED_PERF_EN
      want = 4'hF;
`else
      want = 4'h0;
`endif
      vectors++;
      if (flush_cnt !== want) begin
         miscompares++;
         $display("[TB] FAIL saturation_final: got %h want %h", flush_cnt, want);
      end
   endtask

   task automatic test_random();
      logic [6:0] ec;
      logic [7:0] en;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, ec, en);
         vectors++;
         if (observed_ctl() !== ec) begin
            miscompares++;
            $display("[TB] FAIL random_ctl cyc%0d: got %b want %b", i, observed_ctl(), ec);
         end
         vectors++;
         if (observed_cnt() !== en) begin
            miscompares++;
            $display("[TB] FAIL random_cnt cyc%0d: got %h want %h", i, observed_cnt(), en);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      ld_hazard = 1'b0; redirect = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
      model_reset();
      test_reset();
      test_load_use();
      test_multicycle();
      test_timeout();
      test_priority();
      test_async_reset();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
